// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave side is the cache. The master side is the datapath together with the memory controller.
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iwait;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are combinational, misses are served by a single-word fill, and hits/misses are counted for profiling.
//
// state | meaning
// IDLE  | lookup; a hit is returned this cycle, a miss latches missaddr
// FETCH | iREN held on missaddr until iwait drops, then the frame is filled
module icache_direct #(
    parameter int  NSETS = 16,
    localparam int IDX_W = $clog2(NSETS)
) (
    input  logic           CLK,
    input  logic           nRST,
    icache_direct_if.slave cif,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state, next_state;
    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tag_store  [NSETS];
    logic [31:0]       data_store [NSETS];
    logic [31:0]       missaddr;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic              lookup_hit, miss_start, fill;

    assign req_tag    = cif.imemaddr[31:IDX_W+2];
    assign req_idx    = cif.imemaddr[IDX_W+1:2];
    assign miss_tag   = missaddr[31:IDX_W+2];
    assign miss_idx   = missaddr[IDX_W+1:2];
    assign lookup_hit = cif.imemREN && valid[req_idx] && (tag_store[req_idx] == req_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        cif.ihit     = 1'b0;
        cif.imemload = '0;
        cif.iREN     = 1'b0;
        cif.iaddr    = missaddr;
        miss_start   = 1'b0;
        fill         = 1'b0;
        case (state)
            IDLE: begin
                if (lookup_hit) begin
                    cif.ihit     = 1'b1;
                    cif.imemload = data_store[req_idx];
                end else if (cif.imemREN) begin
                    miss_start = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                // A fetch runs to completion regardless of what the datapath does meanwhile
                cif.iREN = 1'b1;
                if (!cif.iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid      <= '0;
            missaddr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (miss_start) begin
                missaddr <= cif.imemaddr & ~32'd3;
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
            if (cif.ihit && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (fill) valid[miss_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset; valid alone qualifies them
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_store[miss_idx]  <= miss_tag;
            data_store[miss_idx] <= cif.iload;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Directed, scoreboard-checked bench for icache_direct, with a simple wait-state memory model.
// The monitor consumes one queued expectation for every hit cycle it observes.
module tb_icache_direct;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] hit_count, miss_count;

    icache_direct_if mif ();

    icache_direct #(.NSETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .cif        (mif),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    int          hits_seen = 0;
    int          mem_wait = 0;
    bit          started = 1'b0;
    logic [31:0] sb_q[$];
    logic [31:0] fill_addr_q[$];
    int          fill_len_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        if (w == 32'd0) return 32'h2001_0004;
        return 32'hA000_0000 | w;
    endfunction

    // Memory model: iwait high for mem_wait cycles of each fetch, then data with iwait low
    initial begin
        int          cnt;
        logic [31:0] a0;
        cnt = 0;
        a0 = '0;
        mif.iwait = 1'b1;
        mif.iload = '0;
        forever begin
            @(posedge CLK); #1;
            if (mif.iREN) begin
                if (cnt == 0) a0 = mif.iaddr;
                else check("iaddr_stable", mif.iaddr, a0);
                if (cnt < mem_wait) begin
                    mif.iwait = 1'b1;
                    cnt++;
                end else begin
                    mif.iwait = 1'b0;
                    mif.iload = data_of(mif.iaddr);
                    fill_addr_q.push_back(mif.iaddr);
                    fill_len_q.push_back(cnt + 1);
                    cnt = 0;
                end
            end else begin
                mif.iwait = 1'b1;
                cnt = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            if (mif.ihit) begin
                hits_seen++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit: imemload %h addr %h", mif.imemload, mif.imemaddr);
                end else begin
                    check("hit_data", mif.imemload, sb_q.pop_front());
                end
            end else begin
                check("imemload_zero", mif.imemload, 32'd0);
            end
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        mif.imemREN = 1'b0;
        mif.imemaddr = '0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        fill_addr_q.delete();
        fill_len_q.delete();
    endtask

    task automatic check_fill(input string name, input logic [31:0] a, input int len);
        if (fill_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no fill recorded, expected addr %h", name, a);
        end else begin
            check({name, "_addr"}, fill_addr_q.pop_front(), a);
            check({name, "_len"}, fill_len_q.pop_front(), len);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int nh, output int lat);
        int start;
        int cyc;
        start = hits_seen;
        cyc = 0;
        lat = -1;
        for (int i = 0; i < nh; i++) sb_q.push_back(d);
        mif.imemREN = 1'b1;
        mif.imemaddr = a;
        while (hits_seen < start + nh && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (lat < 0 && hits_seen > start) lat = cyc - 1;
        end
        if (hits_seen < start + nh) begin
            check("fetch_timeout", hits_seen - start, nh);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] hc0;

        // reset state
        do_reset();
        started = 1'b1;
        check("rst_ihit", mif.ihit, 1'b0);
        check("rst_imemload", mif.imemload, 32'd0);
        check("rst_iREN", mif.iREN, 1'b0);
        check("rst_iaddr", mif.iaddr, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        // cold miss, two wait cycles
        mem_wait = 2;
        fetch(32'h0, 32'h2001_0004, 1, lat);
        check("cold_latency", lat, 4);
        check_fill("cold_fill", 32'h0, 3);
        check("cold_miss_count", miss_count, 32'd1);
        check("cold_hit_count", hit_count, 32'd1);
        mif.imemREN = 1'b0;

        // conflict eviction on index 0
        do_reset();
        mem_wait = 1;
        fetch(32'h00, 32'h2001_0004, 1, lat);
        check("evict_a_latency", lat, 3);
        fetch(32'h40, 32'hA000_0040, 2, lat);
        check("evict_b_latency", lat, 3);
        fetch(32'h00, 32'h2001_0004, 1, lat);
        check("evict_a2_latency", lat, 3);
        check("evict_miss_count", miss_count, 32'd3);
        check("evict_hit_count", hit_count, 32'd4);
        check_fill("evict_f0", 32'h00, 2);
        check_fill("evict_f1", 32'h40, 2);
        check_fill("evict_f2", 32'h00, 2);
        mif.imemREN = 1'b0;

        // branch while a fill is outstanding
        do_reset();
        mem_wait = 3;
        mif.imemREN = 1'b1;
        mif.imemaddr = 32'h10;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        mif.imemaddr = 32'h80;
        #1;
        check("branch_iREN", mif.iREN, 1'b1);
        check("branch_iaddr", mif.iaddr, 32'h10);
        fetch(32'h80, 32'hA000_0080, 1, lat);
        check("branch_miss_count", miss_count, 32'd2);
        check_fill("branch_f0", 32'h10, 4);
        check_fill("branch_f1", 32'h80, 4);
        fetch(32'h10, 32'hA000_0010, 1, lat);
        check("branch_frame4_hit", lat, 0);
        mif.imemREN = 1'b0;

        // zero-wait memory, sequential fetches
        do_reset();
        mem_wait = 0;
        fetch(32'h0, 32'h2001_0004, 1, lat);
        check("zw0_latency", lat, 2);
        fetch(32'h4, 32'hA000_0004, 1, lat);
        check("zw4_latency", lat, 2);
        fetch(32'h8, 32'hA000_0008, 1, lat);
        check("zw8_latency", lat, 2);
        check("zw_miss_count", miss_count, 32'd3);
        check("zw_hit_count", hit_count, 32'd3);
        check_fill("zw_f0", 32'h0, 1);
        check_fill("zw_f1", 32'h4, 1);
        check_fill("zw_f2", 32'h8, 1);

        // low address bits ignored; stalled repeated hits all counted
        hc0 = hit_count;
        fetch(32'h7, 32'hA000_0004, 5, lat);
        check("lowbit_latency", lat, 0);
        check("stall_hit_delta", hit_count - hc0, 32'd5);
        check("stall_miss_count", miss_count, 32'd3);
        mif.imemREN = 1'b0;

        // reset asserted in the middle of a fetch
        do_reset();
        mem_wait = 5;
        mif.imemREN = 1'b1;
        mif.imemaddr = 32'h24;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("midrst_iREN_before", mif.iREN, 1'b1);
        nRST = 1'b0;
        #1;
        check("midrst_iREN", mif.iREN, 1'b0);
        check("midrst_iaddr", mif.iaddr, 32'd0);
        check("midrst_miss_count", miss_count, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        check("midrst_hit_count_after", hit_count, 32'd0);
        check("midrst_miss_count_after", miss_count, 32'd0);
        fetch(32'h24, 32'hA000_0024, 1, lat);
        check("midrst_refetch_latency", lat, 7);
        check("midrst_refetch_miss", miss_count, 32'd1);
        check_fill("midrst_fill", 32'h24, 6);
        mif.imemREN = 1'b0;

        @(posedge CLK); #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
